intt_butterfly_gs: RTL and testbench

Gentleman-Sande radix-2 butterfly for the inverse NTT datapath over Q = 2013265921. It computes a' = (a + b) mod Q and b' = (a - b)·w·R^-1 mod Q, where R = 2^W and w is a Montgomery-form twiddle. An optional final-stage scale multiplies a' by a Montgomery-form n^-1. It sits downstream of coefficient RAM on the INTT side, mirroring the forward CT butterfly, and adds valid/ready backpressure so it can feed a stalling writeback.

---
 rtl/intt_butterfly_gs.sv | 160 ++++++++++++++++
 tb/tb_intt_butterfly_gs.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/intt_butterfly_gs.sv
// -----------------------------------------------------------------------------
// intt_butterfly_gs
// Gentleman-Sande radix-2 butterfly for the inverse NTT over Q = 2013265921.
//   a' = (a + b) mod Q, optionally multiplied by n^-1 (Montgomery form)
//   b' = (a - b) * w * R^-1 mod Q, with R = 2^W and w in Montgomery form
// Four-stage pipeline with per-stage valid bits and a global stall taken from
// the output handshake. Every register holds while the stall is active.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       input handshake (in_ready is combinational)
//   coeff_a_i, coeff_b_i      input coefficients, < Q
//   twiddle_i                 inverse twiddle in Montgomery form, < Q
//   scale_i, n_inv_mont_i     a-lane n^-1 scaling enable and n^-1*R mod Q
//   out_valid / out_ready     output handshake
//   coeff_a_o, coeff_b_o      butterfly results, registered
// -----------------------------------------------------------------------------
module intt_butterfly_gs #(
    parameter int              W         = 32,
    parameter logic [W-1:0]    Q         = 32'd2013265921,
    parameter logic [W-1:0]    Q_INV_NEG = 32'd2013265919
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] coeff_a_i,
    input  logic [W-1:0] coeff_b_i,
    input  logic [W-1:0] twiddle_i,
    input  logic         scale_i,
    input  logic [W-1:0] n_inv_mont_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] coeff_a_o,
    output logic [W-1:0] coeff_b_o
);

    // Modular add using a (W+1)-bit sum and a single conditional subtract.
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, Q}) begin
            s = s - {1'b0, Q};
        end else begin
            s = s;
        end
        return s[W-1:0];
    endfunction

    // Modular subtract; a negative difference wraps by adding Q back.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        if (x >= y) begin
            d = {1'b0, x} - {1'b0, y};
        end else begin
            d = {1'b0, x} + {1'b0, Q} - {1'b0, y};
        end
        return d[W-1:0];
    endfunction

    // Montgomery reduction: returns t * R^-1 mod Q for t < Q*R.
    // The t + m*Q sum can reach 2^(2W), hence the extra carry bit.
    function automatic logic [W-1:0] mont_reduce(input logic [2*W-1:0] t);
        logic [W-1:0]   m;
        logic [2*W-1:0] mq;
        logic [2*W:0]   u_full;
        logic [W:0]     u;
        m      = t[W-1:0] * Q_INV_NEG;
        mq     = {{W{1'b0}}, m} * {{W{1'b0}}, Q};
        u_full = {1'b0, t} + {1'b0, mq};
        u      = u_full[2*W:W];
        if (u >= {1'b0, Q}) begin
            u = u - {1'b0, Q};
        end else begin
            u = u;
        end
        return u[W-1:0];
    endfunction

    logic stall_s;

    // Stage 1: captured inputs
    logic           s1_v_q, s1_v_d;
    logic [W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_w_q, s1_w_d, s1_ninv_q, s1_ninv_d;
    logic           s1_sc_q, s1_sc_d;
    // Stage 2: sum / difference
    logic           s2_v_q, s2_v_d;
    logic [W-1:0]   s2_sum_q, s2_sum_d, s2_diff_q, s2_diff_d, s2_w_q, s2_w_d, s2_ninv_q, s2_ninv_d;
    logic           s2_sc_q, s2_sc_d;
    // Stage 3: full-width products
    logic           s3_v_q, s3_v_d;
    logic [2*W-1:0] s3_pa_q, s3_pa_d, s3_pb_q, s3_pb_d;
    logic           s3_sc_q, s3_sc_d;
    // Stage 4: reduced results, drive the outputs directly
    logic           s4_v_q, s4_v_d;
    logic [W-1:0]   s4_a_q, s4_a_d, s4_b_q, s4_b_d;

    assign stall_s   = s4_v_q & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = s4_v_q;
    assign coeff_a_o = s4_a_q;
    assign coeff_b_o = s4_b_q;

    // Next-state for every pipeline stage; only applied when not stalled.
    always_comb begin
        s1_v_d    = in_valid;
        s1_a_d    = coeff_a_i;
        s1_b_d    = coeff_b_i;
        s1_w_d    = twiddle_i;
        s1_sc_d   = scale_i;
        s1_ninv_d = n_inv_mont_i;

        s2_v_d    = s1_v_q;
        s2_sum_d  = add_mod(s1_a_q, s1_b_q);
        s2_diff_d = sub_mod(s1_a_q, s1_b_q);
        s2_w_d    = s1_w_q;
        s2_sc_d   = s1_sc_q;
        s2_ninv_d = s1_ninv_q;

        s3_v_d    = s2_v_q;
        s3_sc_d   = s2_sc_q;
        s3_pb_d   = {{W{1'b0}}, s2_diff_q} * {{W{1'b0}}, s2_w_q};
        if (s2_sc_q) begin
            s3_pa_d = {{W{1'b0}}, s2_sum_q} * {{W{1'b0}}, s2_ninv_q};
        end else begin
            // Unscaled sum rides through the product register untouched.
            s3_pa_d = {{W{1'b0}}, s2_sum_q};
        end

        s4_v_d    = s3_v_q;
        s4_b_d    = mont_reduce(s3_pb_q);
        if (s3_sc_q) begin
            s4_a_d = mont_reduce(s3_pa_q);
        end else begin
            s4_a_d = s3_pa_q[W-1:0];
        end
    end

    // Pipeline registers: synchronous clear, hold on stall, advance otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0; s1_a_q <= '0; s1_b_q <= '0; s1_w_q <= '0;
            s1_sc_q <= 1'b0; s1_ninv_q <= '0;
            s2_v_q <= 1'b0; s2_sum_q <= '0; s2_diff_q <= '0; s2_w_q <= '0;
            s2_sc_q <= 1'b0; s2_ninv_q <= '0;
            s3_v_q <= 1'b0; s3_pa_q <= '0; s3_pb_q <= '0; s3_sc_q <= 1'b0;
            s4_v_q <= 1'b0; s4_a_q <= '0; s4_b_q <= '0;
        end else if (!stall_s) begin
            s1_v_q <= s1_v_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d; s1_w_q <= s1_w_d;
            s1_sc_q <= s1_sc_d; s1_ninv_q <= s1_ninv_d;
            s2_v_q <= s2_v_d; s2_sum_q <= s2_sum_d; s2_diff_q <= s2_diff_d; s2_w_q <= s2_w_d;
            s2_sc_q <= s2_sc_d; s2_ninv_q <= s2_ninv_d;
            s3_v_q <= s3_v_d; s3_pa_q <= s3_pa_d; s3_pb_q <= s3_pb_d; s3_sc_q <= s3_sc_d;
            s4_v_q <= s4_v_d; s4_a_q <= s4_a_d; s4_b_q <= s4_b_d;
        end else begin
            s1_v_q <= s1_v_q;
        end
    end

endmodule

// File: tb/tb_intt_butterfly_gs.sv
// -----------------------------------------------------------------------------
// tb_intt_butterfly_gs
// Directed bench for intt_butterfly_gs with hand-computed expected values.
// R mod Q = 268435454 acts as Montgomery "1"; 2R mod Q = 536870908 as "2".
// -----------------------------------------------------------------------------
module tb_intt_butterfly_gs;

    localparam logic [31:0] ONE_M = 32'd268435454;
    localparam logic [31:0] TWO_M = 32'd536870908;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] coeff_a_i;
    logic [31:0] coeff_b_i;
    logic [31:0] twiddle_i;
    logic        scale_i;
    logic [31:0] n_inv_mont_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] coeff_a_o;
    logic [31:0] coeff_b_o;

    int n_checks;
    int n_errors;

    intt_butterfly_gs dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .coeff_a_i    (coeff_a_i),
        .coeff_b_i    (coeff_b_i),
        .twiddle_i    (twiddle_i),
        .scale_i      (scale_i),
        .n_inv_mont_i (n_inv_mont_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .coeff_a_o    (coeff_a_o),
        .coeff_b_o    (coeff_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and require the result exactly 4 cycles later.
    task automatic one_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] tw, input logic sc, input logic [31:0] ninv,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
        in_valid = 1'b1; coeff_a_i = a; coeff_b_i = b; twiddle_i = tw;
        scale_i = sc; n_inv_mont_i = ninv;
        tick();
        in_valid = 1'b0;
        coeff_a_i = 32'd0; coeff_b_i = 32'd0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk_eq({tag, "_early_valid"}, {63'd0, out_valid}, 64'd0);
            tick();
        end
        #1;
        chk_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk_eq({tag, "_a"}, {32'd0, coeff_a_o}, {32'd0, exp_a});
        chk_eq({tag, "_b"}, {32'd0, coeff_b_o}, {32'd0, exp_b});
        tick();
    endtask

    initial begin
        int sent;
        int recv;
        logic exp_rdy;
        logic exp_ov;

        n_checks = 0; n_errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        coeff_a_i = 32'd0; coeff_b_i = 32'd0; twiddle_i = 32'd0;
        scale_i = 1'b0; n_inv_mont_i = 32'd0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk_eq("rst_a", {32'd0, coeff_a_o}, 64'd0);
        chk_eq("rst_b", {32'd0, coeff_b_o}, 64'd0);
        chk_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        // Directed single beats.
        one_beat("basic",   32'd5, 32'd3, ONE_M, 1'b0, 32'd0, 32'd8, 32'd2);
        one_beat("wrap",    32'd3, 32'd5, ONE_M, 1'b0, 32'd0, 32'd8, 32'd2013265919);
        one_beat("sum_q",   32'd2013265920, 32'd1, ONE_M, 1'b0, 32'd0, 32'd0, 32'd2013265919);
        one_beat("tw_zero", 32'd5, 32'd3, 32'd0, 1'b0, 32'd0, 32'd8, 32'd0);
        one_beat("scale",   32'd5, 32'd3, ONE_M, 1'b1, TWO_M, 32'd16, 32'd2);

        // 8 back-to-back beats, out_ready low during cycles 6..9.
        // Beat k: a = 3k+10, b = k -> a' = 4k+10, b' = 2k+10.
        sent = 0; recv = 0;
        twiddle_i = ONE_M; scale_i = 1'b0; n_inv_mont_i = 32'd0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 6 && c <= 9);
            if (sent < 8) begin
                in_valid  = 1'b1;
                coeff_a_i = 32'(3 * sent + 10);
                coeff_b_i = 32'(sent);
            end else begin
                in_valid  = 1'b0;
                coeff_a_i = 32'd0;
                coeff_b_i = 32'd0;
            end
            #1;
            exp_rdy = !(c >= 6 && c <= 9);
            exp_ov  = (c >= 4 && c <= 15);
            chk_eq("bb_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            chk_eq("bb_out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
            if (c >= 6 && c <= 9) begin
                chk_eq("stall_hold_a", {32'd0, coeff_a_o}, 64'd18);
                chk_eq("stall_hold_b", {32'd0, coeff_b_o}, 64'd14);
            end
            if (out_valid && out_ready) begin
                chk_eq("bb_a", {32'd0, coeff_a_o}, 64'(4 * recv + 10));
                chk_eq("bb_b", {32'd0, coeff_b_o}, 64'(2 * recv + 10));
                recv++;
            end
            if (in_valid && exp_rdy) begin
                sent++;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        chk_eq("bb_recv_count", 64'(recv), 64'd8);
        chk_eq("bb_sent_count", 64'(sent), 64'd8);

        // Reset with 3 beats in flight discards them.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; coeff_a_i = 32'd7; coeff_b_i = 32'd1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        one_beat("post_rst", 32'd5, 32'd3, ONE_M, 1'b0, 32'd0, 32'd8, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
